// File: rtl/ioctl_word_loader_pkg.sv
// Shared types and helpers for the ioctl word loader: FSM states and byte-lane mapping.
package ioctl_loader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DRAIN,
    DONE
  } ldr_state_t;

  // Wide enough for a lane index of an 8-byte word.
  localparam int LANE_W = 3;

  function automatic logic [LANE_W-1:0] lane_of(input logic [24:0] addr,
                                                input int         dw_bytes,
                                                input logic       big_endian);
    logic [LANE_W-1:0] lane;
    lane = addr[LANE_W-1:0] & LANE_W'(dw_bytes - 1);
    if (big_endian) lane = LANE_W'(dw_bytes - 1) - lane;
    return lane;
  endfunction

endpackage

// File: rtl/ioctl_word_loader_if.sv
// Bundles the hps_io byte stream, the ROM-load word port and loader status.
interface ioctl_word_loader_if #(
  parameter int DW_BYTES = 2,
  parameter int AW       = 13
);
  logic                    ioctl_download;
  logic [7:0]              ioctl_index;
  logic                    ioctl_wr;
  logic [24:0]             ioctl_addr;
  logic [7:0]              ioctl_dout;
  logic                    ioctl_wait;
  logic [AW-1:0]           ld_addr;
  logic [8*DW_BYTES-1:0]   ld_din;
  logic                    ld_wr;
  logic                    ld_req;
  logic                    loaded;
  logic                    overflow;
  logic [AW:0]             word_count;

  modport master (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, ld_req,
    input  ioctl_wait, ld_addr, ld_din, ld_wr, loaded, overflow, word_count
  );

  modport slave (
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, ld_req,
    output ioctl_wait, ld_addr, ld_din, ld_wr, loaded, overflow, word_count
  );
endinterface

// File: rtl/ioctl_word_loader_fifo.sv
// Synchronous word FIFO with a registered head; push is visible at the head one edge later.
// count/full/empty describe the state after the last edge; flush empties it in one cycle.
module loader_fifo #(
  parameter  int W     = 16,
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q, rd_nxt;
  logic [CW-1:0] cnt_q;
  logic [W-1:0]  head_q;

  assign rd_nxt = rd_q + PW'(1);

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      head_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + PW'(1);
      if (pop)  rd_q <= rd_nxt;
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
      // Head tracks the oldest entry: bypass the write when it becomes the only one.
      if (push && (cnt_q == '0 || (pop && cnt_q == CW'(1))))
        head_q <= wdata;
      else if (pop && cnt_q > CW'(1))
        head_q <= mem_q[rd_nxt];
    end
  end

  assign head  = head_q;
  assign count = cnt_q;
  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);

  a_no_push_when_full: assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: rtl/ioctl_word_loader.sv
// Assembles the hps_io ioctl byte stream into DW_BYTES-wide words for a ROM-load port.
// Last-lane byte at cycle N -> ld_wr at N+1; ioctl_wait holds hps_io off near FIFO full.
module ioctl_word_loader
  import ioctl_loader_pkg::*;
#(
  parameter int DW_BYTES   = 2,
  parameter int AW         = 13,
  parameter int MAX_WORDS  = 8192,
  parameter int FIFO_DEPTH = 4,
  parameter int INDEX      = 0,
  parameter int BIG_ENDIAN = 0
) (
  input logic                clk_sys,
  input logic                reset,
  ioctl_word_loader_if.slave bus
);
  localparam int DW = 8 * DW_BYTES;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  ldr_state_t          state_q;
  logic                dl_q;
  logic [DW-1:0]       asm_q, asm_d;
  logic [DW_BYTES-1:0] lvld_q, lvld_d;
  logic [AW:0]         push_cnt_q, word_count_q;
  logic [AW-1:0]       ld_addr_q;
  logic                overflow_q, loaded_q, wait_q;

  logic                idx_hit, start, fall, byte_hit, last_lane, under_limit;
  logic [LANE_W-1:0]   lane;
  logic [DW-1:0]       merged;
  logic                push_req, push, pop;
  logic [DW-1:0]       fifo_head;
  logic [CW-1:0]       fifo_cnt, cnt_next;
  logic                fifo_full, fifo_empty;

  assign idx_hit     = (bus.ioctl_index == 8'(INDEX));
  assign start       = bus.ioctl_download & ~dl_q & idx_hit & (state_q == IDLE || state_q == DONE);
  assign fall        = ~bus.ioctl_download & dl_q;
  assign byte_hit    = (state_q == LOAD) & bus.ioctl_wr & idx_hit;
  assign lane        = lane_of(bus.ioctl_addr, DW_BYTES, BIG_ENDIAN != 0);
  // Word completion is decided on the address order, independent of byte order.
  assign last_lane   = (lane_of(bus.ioctl_addr, DW_BYTES, 1'b0) == LANE_W'(DW_BYTES - 1));
  assign under_limit = (push_cnt_q < (AW+1)'(MAX_WORDS));
  assign pop         = ~fifo_empty & bus.ld_req;
  assign push        = push_req & under_limit;

  always_comb begin
    merged   = asm_q;
    lvld_d   = lvld_q;
    push_req = 1'b0;
    for (int i = 0; i < DW_BYTES; i++) begin
      if (byte_hit && lane == LANE_W'(i)) begin
        merged[8*i +: 8] = bus.ioctl_dout;
        lvld_d[i]        = 1'b1;
      end
    end
    if (byte_hit && last_lane)
      push_req = 1'b1;
    else if (state_q == DRAIN && lvld_q != '0 && !fifo_full)
      push_req = 1'b1;
    asm_d = merged;
    if (push_req || start) begin
      asm_d  = '0;
      lvld_d = '0;
    end
  end

  always_comb begin
    cnt_next = fifo_cnt + CW'(push) - CW'(pop);
    if (start) cnt_next = '0;
  end

  loader_fifo #(
    .W     (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_sys),
    .rst   (reset),
    .flush (start),
    .push  (push),
    .wdata (merged),
    .pop   (pop),
    .head  (fifo_head),
    .count (fifo_cnt),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q      <= IDLE;
      dl_q         <= 1'b0;
      asm_q        <= '0;
      lvld_q       <= '0;
      push_cnt_q   <= '0;
      word_count_q <= '0;
      ld_addr_q    <= '0;
      overflow_q   <= 1'b0;
      loaded_q     <= 1'b0;
      wait_q       <= 1'b0;
    end else begin
      dl_q   <= bus.ioctl_download;
      asm_q  <= asm_d;
      lvld_q <= lvld_d;
      // Registered from next occupancy so hps_io sees it with the word that filled the slot.
      wait_q <= idx_hit && (cnt_next >= CW'(FIFO_DEPTH - 1));
      if (start) begin
        state_q      <= LOAD;
        push_cnt_q   <= '0;
        word_count_q <= '0;
        ld_addr_q    <= '0;
        overflow_q   <= 1'b0;
        loaded_q     <= 1'b0;
      end else begin
        if (push)                 push_cnt_q <= push_cnt_q + (AW+1)'(1);
        if (push_req && !push)    overflow_q <= 1'b1;
        if (pop) begin
          ld_addr_q    <= ld_addr_q + AW'(1);
          word_count_q <= word_count_q + (AW+1)'(1);
        end
        case (state_q)
          LOAD:    if (fall) state_q <= DRAIN;
          DRAIN:   if (fifo_empty && lvld_q == '0) begin
                     state_q  <= DONE;
                     loaded_q <= 1'b1;
                   end
          default: ;
        endcase
      end
    end
  end

  assign bus.ioctl_wait = wait_q;
  assign bus.ld_addr    = ld_addr_q;
  assign bus.ld_din     = fifo_head;
  assign bus.ld_wr      = ~fifo_empty;
  assign bus.loaded     = loaded_q;
  assign bus.overflow   = overflow_q;
  assign bus.word_count = word_count_q;

endmodule

// File: tb/tb_ioctl_word_loader.sv
// Two loaders share one ioctl stream: A (16-bit LE, index 0, 4-word limit), B (32-bit BE, index 1).
module tb_ioctl_word_loader;

  logic        clk_sys = 1'b0;
  logic        reset   = 1'b1;
  logic        dl      = 1'b0;
  logic [7:0]  idx     = 8'd0;
  logic        wr      = 1'b0;
  logic [24:0] addr    = '0;
  logic [7:0]  dout    = 8'd0;
  logic        req_a   = 1'b0;
  logic        req_b   = 1'b0;

  always #5 clk_sys = ~clk_sys;

  ioctl_word_loader_if #(.DW_BYTES(2), .AW(13)) ifa ();
  ioctl_word_loader_if #(.DW_BYTES(4), .AW(13)) ifb ();

  assign ifa.ioctl_download = dl;
  assign ifa.ioctl_index    = idx;
  assign ifa.ioctl_wr       = wr;
  assign ifa.ioctl_addr     = addr;
  assign ifa.ioctl_dout     = dout;
  assign ifa.ld_req         = req_a;
  assign ifb.ioctl_download = dl;
  assign ifb.ioctl_index    = idx;
  assign ifb.ioctl_wr       = wr;
  assign ifb.ioctl_addr     = addr;
  assign ifb.ioctl_dout     = dout;
  assign ifb.ld_req         = req_b;

  ioctl_word_loader #(
    .DW_BYTES(2), .AW(13), .MAX_WORDS(4), .FIFO_DEPTH(4), .INDEX(0), .BIG_ENDIAN(0)
  ) dut_a (
    .clk_sys (clk_sys),
    .reset   (reset),
    .bus     (ifa)
  );

  ioctl_word_loader #(
    .DW_BYTES(4), .AW(13), .MAX_WORDS(16), .FIFO_DEPTH(4), .INDEX(1), .BIG_ENDIAN(1)
  ) dut_b (
    .clk_sys (clk_sys),
    .reset   (reset),
    .bus     (ifb)
  );

  typedef struct {
    logic [24:0] addr;
    logic [7:0]  dout;
    bit          push;
    logic [31:0] word;
  } vec_t;

  typedef struct {
    logic [12:0] addr;
    logic [63:0] data;
  } exp_t;

  vec_t tbl_a[4];
  vec_t tbl_b[6];
  exp_t qa[$];
  exp_t qb[$];
  int   ea = 0;
  int   eb = 0;
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic push_a(input logic [31:0] w);
    qa.push_back('{addr: 13'(ea), data: 64'(w)});
    ea++;
  endtask

  task automatic push_b(input logic [31:0] w);
    qb.push_back('{addr: 13'(eb), data: 64'(w)});
    eb++;
  endtask

  // Scoreboard: a word is due whenever ld_wr & ld_req ahead of the next rising edge.
  always @(negedge clk_sys) begin : mon
    exp_t e;
    if (!reset && ifa.ld_wr && req_a) begin
      checks++;
      if (qa.size() == 0) begin
        failures++;
        $display("FAIL a_unexpected_word addr=%0d data=0x%0h required=none", ifa.ld_addr, ifa.ld_din);
      end else begin
        e = qa.pop_front();
        if (ifa.ld_addr !== e.addr || 64'(ifa.ld_din) !== e.data) begin
          failures++;
          $display("FAIL a_word actual=%0d/0x%0h required=%0d/0x%0h", ifa.ld_addr, ifa.ld_din, e.addr, e.data);
        end
      end
    end
    if (!reset && ifb.ld_wr && req_b) begin
      checks++;
      if (qb.size() == 0) begin
        failures++;
        $display("FAIL b_unexpected_word addr=%0d data=0x%0h required=none", ifb.ld_addr, ifb.ld_din);
      end else begin
        e = qb.pop_front();
        if (ifb.ld_addr !== e.addr || 64'(ifb.ld_din) !== e.data) begin
          failures++;
          $display("FAIL b_word actual=%0d/0x%0h required=%0d/0x%0h", ifb.ld_addr, ifb.ld_din, e.addr, e.data);
        end
      end
    end
  end

  task automatic put_byte(input logic [24:0] a, input logic [7:0] d);
    int n = 0;
    while ((ifa.ioctl_wait || ifb.ioctl_wait) && n < 500) begin
      @(posedge clk_sys); #1;
      n++;
    end
    check("ioctl_wait_release", 64'(n >= 500), 64'd0);
    wr = 1'b1; addr = a; dout = d;
    @(posedge clk_sys); #1;
    wr = 1'b0;
  endtask

  task automatic dl_start(input logic [7:0] index);
    if (index == 8'd0) ea = 0;
    if (index == 8'd1) eb = 0;
    idx = index;
    dl  = 1'b1;
    @(posedge clk_sys); #1;
  endtask

  task automatic dl_end();
    dl = 1'b0;
    @(posedge clk_sys); #1;
  endtask

  task automatic wait_loaded(input bit sel_b, input string name);
    int n = 0;
    while (!(sel_b ? ifb.loaded : ifa.loaded) && n < 300) begin
      @(posedge clk_sys); #1;
      n++;
    end
    check(name, 64'(sel_b ? ifb.loaded : ifa.loaded), 64'd1);
  endtask

  task automatic check_a_zero(input string tag);
    check({tag, "_ld_wr"},      64'(ifa.ld_wr),      64'd0);
    check({tag, "_wait"},       64'(ifa.ioctl_wait), 64'd0);
    check({tag, "_loaded"},     64'(ifa.loaded),     64'd0);
    check({tag, "_overflow"},   64'(ifa.overflow),   64'd0);
    check({tag, "_ld_addr"},    64'(ifa.ld_addr),    64'd0);
    check({tag, "_ld_din"},     64'(ifa.ld_din),     64'd0);
    check({tag, "_word_count"}, 64'(ifa.word_count), 64'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] w;
    tbl_a[0] = '{25'd0, 8'h34, 1'b0, 32'h0};
    tbl_a[1] = '{25'd1, 8'h12, 1'b1, 32'h1234};
    tbl_a[2] = '{25'd2, 8'h78, 1'b0, 32'h0};
    tbl_a[3] = '{25'd3, 8'h56, 1'b1, 32'h5678};
    tbl_b[0] = '{25'd0, 8'h11, 1'b0, 32'h0};
    tbl_b[1] = '{25'd1, 8'h22, 1'b0, 32'h0};
    tbl_b[2] = '{25'd2, 8'h33, 1'b0, 32'h0};
    tbl_b[3] = '{25'd3, 8'h44, 1'b1, 32'h11223344};
    tbl_b[4] = '{25'd4, 8'h55, 1'b0, 32'h0};
    tbl_b[5] = '{25'd5, 8'h66, 1'b0, 32'h0};

    repeat (3) @(posedge clk_sys);
    #1;
    reset = 1'b0;
    @(posedge clk_sys); #1;
    check_a_zero("reset");
    check("reset_b_ld_wr", 64'(ifb.ld_wr), 64'd0);

    // Basic 16-bit little-endian load.
    req_a = 1'b1;
    dl_start(8'd0);
    foreach (tbl_a[i]) begin
      if (tbl_a[i].push) push_a(tbl_a[i].word);
      put_byte(tbl_a[i].addr, tbl_a[i].dout);
    end
    dl_end();
    wait_loaded(1'b0, "t1_loaded");
    check("t1_word_count", 64'(ifa.word_count), 64'd2);
    check("t1_overflow",   64'(ifa.overflow),   64'd0);

    // 32-bit big-endian with a padded trailing word; A must ignore index 1.
    req_b = 1'b1;
    dl_start(8'd1);
    foreach (tbl_b[i]) begin
      if (tbl_b[i].push) push_b(tbl_b[i].word);
      put_byte(tbl_b[i].addr, tbl_b[i].dout);
    end
    push_b(32'h55660000);
    dl_end();
    wait_loaded(1'b1, "t2_loaded");
    check("t2_word_count", 64'(ifb.word_count), 64'd2);
    check("t2_a_loaded_kept", 64'(ifa.loaded),     64'd1);
    check("t2_a_count_kept",  64'(ifa.word_count), 64'd2);

    // Backpressure: target stalled, wait rises once three words are queued.
    req_a = 1'b0;
    dl_start(8'd0);
    check("t3_loaded_cleared", 64'(ifa.loaded), 64'd0);
    for (int i = 0; i < 3; i++) begin
      w = 16'hA000 + 16'(i);
      push_a(32'(w));
      put_byte(25'(2*i), w[7:0]);
      put_byte(25'(2*i + 1), w[15:8]);
      check($sformatf("t3_wait_after_%0d", i + 1), 64'(ifa.ioctl_wait), 64'(i == 2));
    end
    repeat (3) begin
      @(posedge clk_sys); #1;
      check("t3_hold_din",  64'(ifa.ld_din),  64'hA000);
      check("t3_hold_addr", 64'(ifa.ld_addr), 64'd0);
    end
    req_a = 1'b1;
    w = 16'hA003;
    push_a(32'(w));
    put_byte(25'd6, w[7:0]);
    put_byte(25'd7, w[15:8]);
    dl_end();
    wait_loaded(1'b0, "t3_loaded");
    check("t3_word_count", 64'(ifa.word_count), 64'd4);
    check("t3_overflow",   64'(ifa.overflow),   64'd0);

    // Size limit: five words offered to a four-word loader.
    dl_start(8'd0);
    for (int i = 0; i < 5; i++) begin
      w = 16'hB000 + 16'(i);
      if (i < 4) push_a(32'(w));
      put_byte(25'(2*i), w[7:0]);
      put_byte(25'(2*i + 1), w[15:8]);
    end
    dl_end();
    wait_loaded(1'b0, "t4_loaded");
    check("t4_word_count", 64'(ifa.word_count), 64'd4);
    check("t4_overflow",   64'(ifa.overflow),   64'd1);

    // Foreign index: neither loader reacts.
    dl_start(8'd7);
    for (int i = 0; i < 4; i++) put_byte(25'(i), 8'(8'hC0 + i));
    check("t5_a_wait", 64'(ifa.ioctl_wait), 64'd0);
    dl_end();
    repeat (4) @(posedge clk_sys);
    #1;
    check("t5_a_loaded",     64'(ifa.loaded),     64'd1);
    check("t5_a_word_count", 64'(ifa.word_count), 64'd4);
    check("t5_b_loaded",     64'(ifb.loaded),     64'd1);

    // Reset mid-load with three words queued, then a fresh load from address 0.
    req_a = 1'b0;
    dl_start(8'd0);
    for (int i = 0; i < 6; i++) put_byte(25'(i), 8'(8'hD0 + i));
    reset = 1'b1;
    dl    = 1'b0;
    repeat (2) @(posedge clk_sys);
    #1;
    reset = 1'b0;
    @(posedge clk_sys); #1;
    check_a_zero("t6_reset");
    req_a = 1'b1;
    dl_start(8'd0);
    for (int i = 0; i < 2; i++) begin
      w = 16'hE000 + 16'(i);
      push_a(32'(w));
      put_byte(25'(2*i), w[7:0]);
      put_byte(25'(2*i + 1), w[15:8]);
    end
    dl_end();
    wait_loaded(1'b0, "t6_loaded");
    check("t6_word_count", 64'(ifa.word_count), 64'd2);

    repeat (4) @(posedge clk_sys);
    #1;
    check("final_qa_empty", 64'(qa.size()), 64'd0);
    check("final_qb_empty", 64'(qb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
